hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 155 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and stall controller.
// Arbitrates data-memory stalls, branch flushes (with a pending flag that
// survives a data stall), instruction-memory stalls and load-use bubbles
// into per-stage load enables and flush requests.
// Optional feature macro: HAZARD_CTRL_PERF_EN adds saturating performance
// counters (stall cycles, flush cycles, load-use bubbles).
//
// Handshake note: there is no valid/ready pair here. Every cycle the outputs
// are a pure function of the current state and the inputs; a stage register
// captures its input on a clock edge when its *_ld is 1, and a *_flush forces
// the captured control word to all-zero (a bubble).
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             branch_take,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    output logic             pc_ld,
    output logic             if_id_ld,
    output logic             id_ex_ld,
    output logic             ex_mem_ld,
    output logic             mem_wb_ld,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [1:0]       ctrl_state
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_stall_cyc,
    output logic [CNT_W-1:0] perf_flush_cnt,
    output logic [CNT_W-1:0] perf_lu_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DFREEZE = 2'd1,
        ISQUASH = 2'd2,
        ILLEGAL = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   br_pending;
    logic   br_pending_nxt;
    logic   load_use;

    // Load in EX writes a register the ID instruction reads (x0 never hazards).
    always_comb begin
        load_use = ex_mem_read && (ex_rd != 5'd0) &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                    (id_use_rs2 && (id_rs2 == ex_rd)));
    end

    // Event arbitration: reset, dmem stall, flush, squash, imem stall, load-use.
    always_comb begin
        pc_ld          = 1'b1;
        if_id_ld       = 1'b1;
        id_ex_ld       = 1'b1;
        ex_mem_ld      = 1'b1;
        mem_wb_ld      = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        state_nxt      = RUN;
        br_pending_nxt = br_pending;

        if (!rst) begin
            pc_ld          = 1'b0;
            if_id_ld       = 1'b0;
            id_ex_ld       = 1'b0;
            ex_mem_ld      = 1'b0;
            mem_wb_ld      = 1'b0;
            if_id_flush    = 1'b1;
            id_ex_flush    = 1'b1;
            br_pending_nxt = 1'b0;
        end else if (dmem_stall) begin
            // Whole pipe freezes; a branch resolved now is remembered.
            pc_ld          = 1'b0;
            if_id_ld       = 1'b0;
            id_ex_ld       = 1'b0;
            ex_mem_ld      = 1'b0;
            mem_wb_ld      = 1'b0;
            state_nxt      = DFREEZE;
            br_pending_nxt = br_pending | branch_take;
        end else if (branch_take || br_pending) begin
            // Redirect: both younger stages become bubbles.
            if_id_flush    = 1'b1;
            id_ex_flush    = 1'b1;
            br_pending_nxt = 1'b0;
            state_nxt      = imem_stall ? ISQUASH : RUN;
        end else if (state == ISQUASH) begin
            // The fetch still in flight is wrong-path: never let it into ID.
            if_id_flush = 1'b1;
            if (imem_stall) begin
                pc_ld     = 1'b0;
                state_nxt = ISQUASH;
            end
        end else if (imem_stall) begin
            pc_ld       = 1'b0;
            if_id_flush = 1'b1;
        end else if (load_use) begin
            // Hold PC and IF/ID one cycle, insert a bubble into EX.
            pc_ld       = 1'b0;
            if_id_ld    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    // State and pending-branch registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= RUN;
            br_pending <= 1'b0;
        end else begin
            state      <= state_nxt;
            br_pending <= br_pending_nxt;
        end
    end

    assign ctrl_state = rst ? state : RUN;

`ifdef HAZARD_CTRL_PERF_EN
    logic flush_cyc;
    logic lu_bubble;

    // A flush cycle is the only case with both flushes and all loads high;
    // a load-use bubble is the only case flushing ID/EX but not IF/ID.
    assign flush_cyc = rst & pc_ld & if_id_flush & id_ex_flush;
    assign lu_bubble = rst & id_ex_flush & ~if_id_flush;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_stall_cyc <= '0;
            perf_flush_cnt <= '0;
            perf_lu_cnt    <= '0;
        end else begin
            if (!pc_ld && (perf_stall_cyc != '1))
                perf_stall_cyc <= perf_stall_cyc + CNT_W'(1);
            if (flush_cyc && (perf_flush_cnt != '1))
                perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
            if (lu_bubble && (perf_lu_cnt != '1))
                perf_lu_cnt <= perf_lu_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl against an
// event-table reference model. Build with HAZARD_CTRL_PERF_EN to also
// check the performance counters.
module tb_hazard_ctrl;

    localparam int TB_CNT_W = 4;
    localparam int W        = 9;

    localparam int EV_RESET   = 0;
    localparam int EV_DSTALL  = 1;
    localparam int EV_FLUSH   = 2;
    localparam int EV_SQ_HOLD = 3;
    localparam int EV_SQ_DONE = 4;
    localparam int EV_ISTALL  = 5;
    localparam int EV_LU      = 6;
    localparam int EV_NONE    = 7;

    logic       clk;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read;
    logic       branch_take, imem_stall, dmem_stall;
    logic       pc_ld, if_id_ld, id_ex_ld, ex_mem_ld, mem_wb_ld;
    logic       if_id_flush, id_ex_flush;
    logic [1:0] ctrl_state;
`ifdef HAZARD_CTRL_PERF_EN
    logic [TB_CNT_W-1:0] perf_stall_cyc, perf_flush_cnt, perf_lu_cnt;
    logic [3*TB_CNT_W-1:0] perf_q[$];
`endif

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state: pipeline mode, remembered branch, counters.
    int m_mode = 0;   // 0 running, 1 data-frozen, 2 squashing a fetch
    bit m_pend = 0;
    int m_stall = 0, m_flush = 0, m_lu = 0;
    int cnt_max = (1 << TB_CNT_W) - 1;

    hazard_ctrl #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .branch_take(branch_take), .imem_stall(imem_stall), .dmem_stall(dmem_stall),
        .pc_ld(pc_ld), .if_id_ld(if_id_ld), .id_ex_ld(id_ex_ld),
        .ex_mem_ld(ex_mem_ld), .mem_wb_ld(mem_wb_ld),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ctrl_state(ctrl_state)
`ifdef HAZARD_CTRL_PERF_EN
        ,
        .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt),
        .perf_lu_cnt(perf_lu_cnt)
`endif
    );

    // Clock and initial reset level.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Outputs per event: {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush}.
    function automatic logic [6:0] ev_outputs(input int ev);
        case (ev)
            EV_RESET:   return 7'b00000_11;
            EV_DSTALL:  return 7'b00000_00;
            EV_FLUSH:   return 7'b11111_11;
            EV_SQ_HOLD: return 7'b01111_10;
            EV_SQ_DONE: return 7'b11111_10;
            EV_ISTALL:  return 7'b01111_10;
            EV_LU:      return 7'b00111_01;
            default:    return 7'b11111_00;
        endcase
    endfunction

    function automatic int sat_inc(input int v);
        return (v < cnt_max) ? v + 1 : v;
    endfunction

    // One cycle of stimulus: apply inputs, predict this cycle, advance model.
    task automatic drive(input bit r, input logic [4:0] rs1, input logic [4:0] rs2,
                         input bit u1, input bit u2, input bit mr, input logic [4:0] rd,
                         input bit bt, input bit is, input bit ds);
        logic [4:0] src[2];
        bit         use_src[2];
        bit         lu;
        int         ev;
        logic [6:0] o;
        @(posedge clk);
        #1;
        rst = r; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
        ex_mem_read = mr; ex_rd = rd; branch_take = bt; imem_stall = is; dmem_stall = ds;

        src[0] = rs1; src[1] = rs2; use_src[0] = u1; use_src[1] = u2;
        lu = 1'b0;
        if (mr && rd != 5'd0)
            for (int i = 0; i < 2; i++)
                if (use_src[i] && src[i] == rd) lu = 1'b1;

        if (!r)                 ev = EV_RESET;
        else if (ds)            ev = EV_DSTALL;
        else if (bt || m_pend)  ev = EV_FLUSH;
        else if (m_mode == 2)   ev = is ? EV_SQ_HOLD : EV_SQ_DONE;
        else if (is)            ev = EV_ISTALL;
        else if (lu)            ev = EV_LU;
        else                    ev = EV_NONE;

        o = ev_outputs(ev);
        exp_q.push_back({o, (ev == EV_RESET) ? 2'd0 : 2'(m_mode)});
`ifdef HAZARD_CTRL_PERF_EN
        perf_q.push_back({TB_CNT_W'(m_stall), TB_CNT_W'(m_flush), TB_CNT_W'(m_lu)});
`endif

        case (ev)
            EV_RESET:   begin m_mode = 0; m_pend = 0; end
            EV_DSTALL:  begin m_mode = 1; m_pend = m_pend | bt; end
            EV_FLUSH:   begin m_mode = is ? 2 : 0; m_pend = 0; end
            EV_SQ_HOLD: m_mode = 2;
            default:    m_mode = 0;
        endcase
        if (ev == EV_RESET) begin
            m_stall = 0; m_flush = 0; m_lu = 0;
        end else begin
            if (o[6] == 1'b0) m_stall = sat_inc(m_stall);
            if (ev == EV_FLUSH) m_flush = sat_inc(m_flush);
            if (ev == EV_LU) m_lu = sat_inc(m_lu);
        end
    endtask

    task automatic idle();
        drive(1, 5'd1, 5'd2, 1, 1, 0, 5'd0, 0, 0, 0);
    endtask

    // Monitor: every cycle carries a response; compare mid-cycle.
    always @(negedge clk) begin
        logic [W-1:0] exp_v;
        logic [W-1:0] got_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            got_v = {pc_ld, if_id_ld, id_ex_ld, ex_mem_ld, mem_wb_ld,
                     if_id_flush, id_ex_flush, ctrl_state};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL outputs @%0t: got ld/fl/st=%b required %b", $time, got_v, exp_v);
            end
`ifdef HAZARD_CTRL_PERF_EN
            begin
                logic [3*TB_CNT_W-1:0] exp_p;
                exp_p = perf_q.pop_front();
                checks++;
                if ({perf_stall_cyc, perf_flush_cnt, perf_lu_cnt} !== exp_p) begin
                    errors++;
                    $display("FAIL perf @%0t: got %h required %h", $time,
                             {perf_stall_cyc, perf_flush_cnt, perf_lu_cnt}, exp_p);
                end
            end
`endif
        end
    end

    // Directed scenarios, then randomized traffic, then report.
    initial begin
        int budget;
        rst = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_mem_read = 0; ex_rd = '0; branch_take = 0; imem_stall = 0; dmem_stall = 0;

        // Reset
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        // Load-use on rs2, then the bubble has cleared EX
        drive(1, 5'd3, 5'd5, 0, 1, 1, 5'd5, 0, 0, 0);
        drive(1, 5'd3, 5'd5, 0, 1, 0, 5'd0, 0, 0, 0);
        // Load to x0 never hazards
        drive(1, 5'd0, 5'd7, 1, 0, 1, 5'd0, 0, 0, 0);
        // Unused source matching the load is not a hazard
        drive(1, 5'd9, 5'd4, 0, 1, 1, 5'd9, 0, 0, 0);
        // Data freeze with a branch mid-freeze, then flush on release
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        // Branch with fetch outstanding two more cycles
        drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        // Plain imem stall, and imem stall beating a load-use
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(1, 5'd6, 5'd0, 1, 0, 1, 5'd6, 0, 1, 0);
        idle();
        // Reset during a freeze with a pending branch discards it
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        idle();
        // Reset during a squash discards the squash
        drive(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle();

        // Randomized traffic with a small register pool so hazards are frequent
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 59) != 0,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0);
        end

        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(posedge clk);
            budget++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
